// File: rtl/apb_decode_bridge_pkg.sv
// Shared types and constants for the AXI-lite to APB decode bridge.
package apb_decode_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_br_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Slave index width; a single slave still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_decode_bridge_addr_decoder.sv
// Combinational address decode: maps an address to a slave index and hit flag.
module apb_addr_decoder
  import apb_decode_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned       SLV_SIZE_LOG2 = 12,
  parameter int unsigned       NUM_SLV       = 4,
  parameter int unsigned       IDX_W         = idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] page;

  assign off  = addr - BASE_ADDR;
  assign page = off >> SLV_SIZE_LOG2;
  assign hit  = (addr >= BASE_ADDR) && (page < ADDR_W'(NUM_SLV));
  assign idx  = page[IDX_W-1:0];

endmodule

// File: rtl/apb_decode_bridge.sv
// AXI-lite slave to APB4 master bridge with per-slave PSEL decode,
// wait-state support, access timeout and AXI error responses.
module apb_decode_bridge
  import apb_decode_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       NUM_SLV       = 4,
  parameter int unsigned       SLV_SIZE_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned       TIMEOUT       = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned IDX_W  = idx_width(NUM_SLV);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned STRB_W = DATA_W / 8;

  apb_br_state_e             state, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      last_wr, last_wr_d;
  logic [NUM_SLV-1:0]        psel_d;
  logic                      penable_d, pwrite_d, bvalid_d, rvalid_d;
  logic [ADDR_W-1:0]         paddr_d;
  logic [DATA_W-1:0]         pwdata_d, rdata_d;
  logic [STRB_W-1:0]         pstrb_d;
  logic [1:0]                bresp_d, rresp_d;

  logic                      wr_pend, rd_pend, pick_wr, pick_rd;
  logic [ADDR_W-1:0]         req_addr;
  logic [IDX_W-1:0]          dec_idx;
  logic                      dec_hit;
  logic                      sel_ready, sel_err;
  logic [DATA_W-1:0]         sel_rdata;

  // Request arbitration; last_wr only flips when both directions compete.
  assign wr_pend  = awvalid && wvalid;
  assign rd_pend  = arvalid;
  assign pick_wr  = (state == IDLE) && wr_pend && (!rd_pend || !last_wr);
  assign pick_rd  = (state == IDLE) && rd_pend && !pick_wr;
  assign awready  = pick_wr;
  assign wready   = pick_wr;
  assign arready  = pick_rd;
  assign req_addr = pick_wr ? awaddr : araddr;

  apb_addr_decoder #(
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .NUM_SLV       (NUM_SLV),
    .IDX_W         (IDX_W)
  ) u_dec (
    .addr (req_addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[int'(idx_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx_q   <= '0;
      cnt     <= '0;
      last_wr <= 1'b0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      state   <= state_d;
      idx_q   <= idx_d;
      cnt     <= cnt_d;
      last_wr <= last_wr_d;
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      pstrb   <= pstrb_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
      rvalid  <= rvalid_d;
      rresp   <= rresp_d;
      rdata   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx_q;
    cnt_d     = cnt;
    last_wr_d = last_wr;
    psel_d    = psel;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pstrb_d   = pstrb;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    rvalid_d  = rvalid;
    rresp_d   = rresp;
    rdata_d   = rdata;

    unique case (state)
      IDLE: begin
        if (pick_wr || pick_rd) begin
          if (wr_pend && rd_pend) last_wr_d = pick_wr;
          pwrite_d = pick_wr;
          paddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          pwdata_d = pick_wr ? wdata : '0;
          pstrb_d  = pick_wr ? wstrb : '0;
          idx_d    = dec_idx;
          if (dec_hit) begin
            psel_d  = NUM_SLV'(1) << dec_idx;
            state_d = SETUP;
          end else begin
            // Unmapped address: answer straight away without touching APB.
            state_d = RESP;
            if (pick_wr) begin
              bvalid_d = 1'b1;
              bresp_d  = RESP_DECERR;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = RESP_DECERR;
              rdata_d  = '0;
            end
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready || (cnt == CNT_W'(TIMEOUT - 1))) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (pwrite) begin
            bvalid_d = 1'b1;
            bresp_d  = (sel_ready && !sel_err) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = (sel_ready && !sel_err) ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = sel_ready ? sel_rdata : '0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if ((bvalid && bready) || (rvalid && rready)) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_decode_bridge.sv
// Directed cycle-accurate bench for apb_decode_bridge (TIMEOUT=8).
module tb_apb_decode_bridge;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, arvalid, bready, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, arready, bvalid, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, paddr, pwdata;
  logic         pwrite, penable;
  logic [3:0]   pstrb, psel;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_decode_bridge #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    prdata = '0; pready = 4'hF; pslverr = 4'h0;
    #12;
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_ready", {29'd0, awready, wready, arready}, 0);
    reset_n = 1'b1;
    tick();

    // 1: zero-wait write to slave 1
    drive_wr(32'h4000_1008, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_awready", {30'd0, awready, wready}, 32'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_psel", 32'(psel), 32'h2);
    chk("t1_penable_setup", 32'(penable), 0);
    chk("t1_paddr", paddr, 32'h4000_1008);
    chk("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("t1_pstrb", 32'(pstrb), 32'hF);
    chk("t1_pwrite", 32'(pwrite), 1);
    tick();
    chk("t1_penable_access", 32'(penable), 1);
    chk("t1_bvalid_c2", 32'(bvalid), 0);
    tick();
    chk("t1_bvalid_c3", 32'(bvalid), 1);
    chk("t1_bresp", 32'(bresp), 0);
    chk("t1_psel_done", 32'(psel), 0);
    tick();
    chk("t1_bvalid_clr", 32'(bvalid), 0);

    // 2: read slave 3 with two wait states
    pready = 4'b0111;
    prdata[96 +: 32] = 32'h1234_5678;
    araddr = 32'h4000_3004; arvalid = 1'b1;
    #1;
    chk("t2_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    chk("t2_psel", 32'(psel), 32'h8);
    chk("t2_paddr", paddr, 32'h4000_3004);
    chk("t2_pstrb", 32'(pstrb), 0);
    tick();
    tick();
    chk("t2_rvalid_c3", 32'(rvalid), 0);
    tick();
    pready = 4'hF;
    chk("t2_rvalid_c4", 32'(rvalid), 0);
    tick();
    chk("t2_rvalid_c5", 32'(rvalid), 1);
    chk("t2_rdata", rdata, 32'h1234_5678);
    chk("t2_rresp", 32'(rresp), 0);
    tick();

    // 3: decode errors, unmapped and below base
    araddr = 32'h4000_4000; arvalid = 1'b1;
    #1;
    chk("t3a_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    chk("t3a_rvalid", 32'(rvalid), 1);
    chk("t3a_rresp", 32'(rresp), 3);
    chk("t3a_rdata", rdata, 0);
    chk("t3a_psel", 32'(psel), 0);
    tick();
    araddr = 32'h3FFF_FFFC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t3b_rvalid", 32'(rvalid), 1);
    chk("t3b_rresp", 32'(rresp), 3);
    chk("t3b_psel", 32'(psel), 0);
    tick();

    // 4: timeout on slave 2, then pslverr on slave 2
    pready = 4'b1011;
    drive_wr(32'h4000_2000, 32'h0000_00AA, 4'h1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    n = 0;
    while (penable && n < 20) begin
      n++;
      tick();
    end
    chk("t4_penable_cycles", n, 8);
    chk("t4_psel", 32'(psel), 0);
    chk("t4_bvalid", 32'(bvalid), 1);
    chk("t4_bresp", 32'(bresp), 2);
    tick();
    pready = 4'hF; pslverr = 4'b0100;
    drive_wr(32'h4000_2010, 32'h5555_0000, 4'hC);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    chk("t4_err_bvalid", 32'(bvalid), 1);
    chk("t4_err_bresp", 32'(bresp), 2);
    pslverr = 4'h0;
    tick();

    // 5: simultaneous write+read, write first, bready held low
    bready = 1'b0;
    prdata[0 +: 32] = 32'hA5A5_0000;
    drive_wr(32'h4000_0000, 32'h1111_2222, 4'hF);
    araddr = 32'h4000_0010; arvalid = 1'b1;
    #1;
    chk("t5_awready_first", {30'd0, awready, arready}, 32'h2);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk("t5_arready_busy", 32'(arready), 0);
    chk("t5_psel", 32'(psel), 32'h1);
    tick();
    tick();
    chk("t5_bvalid_c3", 32'(bvalid), 1);
    tick();
    chk("t5_bvalid_c4", {30'd0, bvalid, 1'b0} | 32'(bresp), 32'h2);
    tick();
    chk("t5_hold_c5", {29'd0, bvalid, arready, |psel}, 32'h4);
    tick();
    bready = 1'b1;
    chk("t5_bvalid_c6", 32'(bvalid), 1);
    tick();
    chk("t5_after_b", {30'd0, bvalid, arready}, 32'h1);
    tick();
    arvalid = 1'b0;
    chk("t5_rd_pwrite", 32'(pwrite), 0);
    tick();
    tick();
    chk("t5_rvalid", 32'(rvalid), 1);
    chk("t5_rdata", rdata, 32'hA5A5_0000);
    tick();
    drive_wr(32'h4000_0004, 32'h3333_4444, 4'hF);
    araddr = 32'h4000_0008; arvalid = 1'b1;
    #1;
    chk("t5_pair2_read_first", {30'd0, awready, arready}, 32'h1);
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    chk("t5_pair2_rvalid", 32'(rvalid), 1);
    tick();
    chk("t5_pair2_awready", 32'(awready), 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t5_pair2_pwdata", pwdata, 32'h3333_4444);
    tick();
    tick();
    chk("t5_pair2_bvalid", 32'(bvalid), 1);
    tick();

    // 6: reset during ACCESS, then a fresh write
    pready = 4'b1101;
    drive_wr(32'h4000_1000, 32'hCAFE_F00D, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t6_in_access", {30'd0, penable, psel[1]}, 32'h3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_clear", {28'd0, psel}, 0);
    chk("t6_rst_penable", {30'd0, penable, bvalid}, 0);
    #10;
    reset_n = 1'b1;
    pready = 4'hF;
    tick();
    drive_wr(32'h4000_1004, 32'h0BAD_CAFE, 4'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_psel", 32'(psel), 32'h2);
    chk("t6_pstrb", 32'(pstrb), 32'h3);
    tick();
    tick();
    chk("t6_bvalid", 32'(bvalid), 1);
    chk("t6_bresp", 32'(bresp), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
